// File: rtl/time_manager_pkg.sv
// Shared time format, the reserved "no event" value, FSM encoding and a helper
// giving the min-tree latency for a given clock count.
package time_manager_pkg;

    localparam int TIME_FORMAT_WIDTH = 32;

    typedef logic [TIME_FORMAT_WIDTH-1:0] time_format_t;

    // All ones never occurs as a real edge time; it marks an absent event.
    localparam time_format_t TIME_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // Input register stage plus one registered level per halving.
    function automatic int tree_latency(input int n_clocks);
        return 1 + $clog2(n_clocks);
    endfunction

endpackage

// File: rtl/time_manager_if.sv
// Time/gating bus between the emulated clocks plus run control (master side)
// and the central scheduler (slave side).
interface time_manager_if #(
    parameter int N_CLOCKS   = 4,
    parameter int TIME_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [N_CLOCKS*TIME_WIDTH-1:0] time_clocks;
    logic                           run;
    logic [TIME_WIDTH-1:0]          time_stop;
    logic [TIME_WIDTH-1:0]          time_next;
    logic                           issue;
    logic [TIME_WIDTH-1:0]          time_emu;
    logic [CNT_WIDTH-1:0]           event_count;
    logic                           done;
    logic                           busy;

    modport master (
        output time_clocks, run, time_stop,
        input  time_next, issue, time_emu, event_count, done, busy
    );

    modport slave (
        input  time_clocks, run, time_stop,
        output time_next, issue, time_emu, event_count, done, busy
    );
endinterface

// File: rtl/time_manager_min_tree.sv
// Registered binary min reduction over all clock edge times. Leaves are padded
// to a power of two with the "no event" value so odd leftovers pass through.
module min_tree
    import time_manager_pkg::*;
#(
    parameter int N_CLOCKS   = 4,
    parameter int TIME_WIDTH = TIME_FORMAT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CLOCKS*TIME_WIDTH-1:0] time_clocks,
    output logic [TIME_WIDTH-1:0]          min_time
);

    localparam int LATENCY = tree_latency(N_CLOCKS);
    localparam int LEVELS  = LATENCY - 1;
    localparam int LEAVES  = 1 << LEVELS;
    localparam int NODES   = 2 * LEAVES - 1;
    localparam logic [TIME_WIDTH-1:0] NO_EVENT = '1;

    // Heap layout: node 0 is the root, children of k are 2k+1 and 2k+2,
    // leaves occupy the last LEAVES slots. Every node is a register.
    logic [TIME_WIDTH-1:0] node_reg  [NODES];
    logic [TIME_WIDTH-1:0] node_next [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_node
            if (gi < LEAVES - 1) begin : g_inner
                assign node_next[gi] = (node_reg[2*gi+1] < node_reg[2*gi+2]) ?
                                       node_reg[2*gi+1] : node_reg[2*gi+2];
            end else if (gi - (LEAVES - 1) < N_CLOCKS) begin : g_leaf
                assign node_next[gi] = time_clocks[(gi-(LEAVES-1))*TIME_WIDTH +: TIME_WIDTH];
            end else begin : g_pad
                assign node_next[gi] = NO_EVENT;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                node_reg[i] <= NO_EVENT;
            end
        end else begin
            node_reg <= node_next;
        end
    end

    assign min_time = node_reg[0];

endmodule

// File: rtl/time_manager.sv
// Emulation-time scheduler: waits for the min-tree to settle, then either issues
// the global minimum as the next event time or stops at time_stop / no event.
module time_manager
    import time_manager_pkg::*;
#(
    parameter int N_CLOCKS   = 4,
    parameter int TIME_WIDTH = TIME_FORMAT_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    time_manager_if.slave tm
);

    localparam int LATENCY = tree_latency(N_CLOCKS);
    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY + 1);
    localparam logic [TIME_WIDTH-1:0] NO_EVENT = '1;

    state_t                 state_reg, state_next;
    logic [7:0]             wait_cnt_reg, wait_cnt_next;
    logic [TIME_WIDTH-1:0]  time_next_reg, time_next_next;
    logic [TIME_WIDTH-1:0]  time_emu_reg, time_emu_next;
    logic [CNT_WIDTH-1:0]   event_count_reg, event_count_next;
    logic                   done_reg, done_next;
    logic                   issue_reg, issue_next;
    logic [TIME_WIDTH-1:0]  tree_min;
    logic                   stop_hit;
    logic                   wait_last;

    min_tree #(
        .N_CLOCKS   (N_CLOCKS),
        .TIME_WIDTH (TIME_WIDTH)
    ) u_min_tree (
        .clk         (clk),
        .rst_n       (rst_n),
        .time_clocks (tm.time_clocks),
        .min_time    (tree_min)
    );

    assign stop_hit  = (tree_min >= tm.time_stop) || (tree_min == NO_EVENT);
    assign wait_last = (wait_cnt_reg <= 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= '0;
            time_next_reg   <= NO_EVENT;
            time_emu_reg    <= '0;
            event_count_reg <= '0;
            done_reg        <= 1'b0;
            issue_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            time_next_reg   <= time_next_next;
            time_emu_reg    <= time_emu_next;
            event_count_reg <= event_count_next;
            done_reg        <= done_next;
            issue_reg       <= issue_next;
        end
    end

    // run is only consulted when leaving WAIT, so a drop mid-ISSUE is ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (tm.run && !done_reg) state_next = ST_WAIT;
            ST_WAIT:  if (wait_last) state_next = tm.run ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_next = stop_hit ? ST_IDLE : ST_WAIT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_next    = wait_cnt_reg;
        time_next_next   = time_next_reg;
        time_emu_next    = time_emu_reg;
        event_count_next = event_count_reg;
        done_next        = done_reg;
        issue_next       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                time_next_next = NO_EVENT;
                if (tm.run && !done_reg) wait_cnt_next = WAIT_LOAD;
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 8'd1;
                if (wait_last && !tm.run) time_next_next = NO_EVENT;
            end
            ST_ISSUE: begin
                if (stop_hit) begin
                    done_next      = 1'b1;
                    time_next_next = NO_EVENT;
                end else begin
                    time_next_next   = tree_min;
                    time_emu_next    = tree_min;
                    issue_next       = 1'b1;
                    event_count_next = event_count_reg + CNT_WIDTH'(1);
                    wait_cnt_next    = WAIT_LOAD;
                end
            end
            default: time_next_next = NO_EVENT;
        endcase
    end

    assign tm.time_next   = time_next_reg;
    assign tm.issue       = issue_reg;
    assign tm.time_emu    = time_emu_reg;
    assign tm.event_count = event_count_reg;
    assign tm.done        = done_reg;
    assign tm.busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_time_manager.sv
// Directed and randomized scenarios: clock models advance on issued times, and a
// reference event list derived from the clocks' periods/phases checks every issue.
module tb_time_manager;
    import time_manager_pkg::*;

    localparam int N      = 4;
    localparam int TW     = 32;
    localparam int CW     = 32;
    localparam int PERIOD = tree_latency(N) + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic load  = 1'b1;

    time_manager_if #(.N_CLOCKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) tif ();

    time_manager #(.N_CLOCKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tm    (tif)
    );

    always #5 clk = ~clk;

    logic [TW-1:0] tc      [N];
    logic [TW-1:0] cfg_inc [N];
    logic [TW-1:0] cfg_ph  [N];
    logic [TW-1:0] exp_final [N];
    logic [TW-1:0] exp_q [$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Emulated clocks: fire when an issued time equals their next edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (load) tc[i] <= cfg_ph[i];
            else if (tif.issue && tc[i] == tif.time_next) tc[i] <= tc[i] + cfg_inc[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign tif.time_clocks[gi*TW +: TW] = tc[gi];
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Event list = sorted distinct edge times below stop, all clocks merged.
    task automatic build_expected(input logic [TW-1:0] stop);
        logic [TW-1:0] nt [N];
        logic [TW-1:0] m;
        exp_q.delete();
        for (int i = 0; i < N; i++) nt[i] = cfg_ph[i];
        for (int k = 0; k < 500; k++) begin
            m = TIME_MAX;
            for (int i = 0; i < N; i++) if (nt[i] < m) m = nt[i];
            if (m == TIME_MAX || m >= stop) break;
            exp_q.push_back(m);
            for (int i = 0; i < N; i++) if (nt[i] == m) nt[i] = nt[i] + cfg_inc[i];
        end
        for (int i = 0; i < N; i++) exp_final[i] = nt[i];
    endtask

    task automatic check_reset_values(input string name);
        chk({name, " rst time_next"}, 64'(tif.time_next), 64'(TIME_MAX));
        chk({name, " rst issue"}, 64'(tif.issue), 64'd0);
        chk({name, " rst time_emu"}, 64'(tif.time_emu), 64'd0);
        chk({name, " rst event_count"}, 64'(tif.event_count), 64'd0);
        chk({name, " rst done"}, 64'(tif.done), 64'd0);
        chk({name, " rst busy"}, 64'(tif.busy), 64'd0);
    endtask

    task automatic run_case(input string name, input logic [TW-1:0] stop,
                            input int pause_after, input int abort_after);
        int idx, last, pause_left;
        bit finished;
        build_expected(stop);
        rst_n = 1'b0;
        tif.run = 1'b0;
        tif.time_stop = stop;
        load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        check_reset_values(name);
        tif.run = 1'b1;
        idx = 0;
        last = -1;
        pause_left = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (tif.issue) begin
                $display("%s: issue #%0d time_next=%0d event_count=%0d cycle=%0d",
                         name, idx, tif.time_next, tif.event_count, cyc);
                if (idx < exp_q.size()) begin
                    chk({name, " time_next"}, 64'(tif.time_next), 64'(exp_q[idx]));
                    chk({name, " time_emu"}, 64'(tif.time_emu), 64'(exp_q[idx]));
                    if (last >= 0) chk({name, " spacing"}, 64'(cyc - last), 64'(PERIOD));
                end else begin
                    chk({name, " issue count"}, 64'(idx + 1), 64'(exp_q.size()));
                end
                last = cyc;
                idx++;
                if (abort_after > 0 && idx == abort_after) begin
                    @(posedge clk);
                    @(posedge clk);
                    #2;
                    chk({name, " busy before rst"}, 64'(tif.busy), 64'd1);
                    rst_n = 1'b0;
                    #1;
                    check_reset_values({name, " async"});
                    return;
                end
                if (pause_after > 0 && idx == pause_after) begin
                    tif.run = 1'b0;
                    pause_left = 10;
                end
            end else if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) begin
                    chk({name, " paused time_next"}, 64'(tif.time_next), 64'(TIME_MAX));
                    chk({name, " paused busy"}, 64'(tif.busy), 64'd0);
                    tif.run = 1'b1;
                    last = -1;
                end
            end
            if (tif.done && !tif.busy) begin
                finished = 1'b1;
                break;
            end
        end
        chk({name, " finished in budget"}, 64'(finished), 64'd1);
        chk({name, " issues seen"}, 64'(idx), 64'(exp_q.size()));
        chk({name, " event_count"}, 64'(tif.event_count), 64'(exp_q.size()));
        chk({name, " final time_next"}, 64'(tif.time_next), 64'(TIME_MAX));
        chk({name, " done"}, 64'(tif.done), 64'd1);
        for (int i = 0; i < N; i++) chk({name, " clock final"}, 64'(tc[i]), 64'(exp_final[i]));
        $display("%s: finished with %0d events", name, idx);
    endtask

    initial begin
        logic [TW-1:0] stop;
        int nact;
        tif.run = 1'b0;
        tif.time_stop = '0;
        for (int i = 0; i < N; i++) begin
            cfg_inc[i] = 32'd1;
            cfg_ph[i]  = TIME_MAX;
        end

        // Two clocks, inc 3 and 5: events 0,3,5,6,9,10,12,15 then stop at 18.
        cfg_inc[0] = 32'd3; cfg_ph[0] = 32'd0;
        cfg_inc[1] = 32'd5; cfg_ph[1] = 32'd0;
        run_case("inc3_5", 32'd16, 0, 0);

        // Four in-phase clocks with equal increments fire together.
        for (int i = 0; i < N; i++) begin
            cfg_inc[i] = 32'd4;
            cfg_ph[i]  = 32'd0;
        end
        run_case("in_phase", 32'd20, 0, 0);

        // Three clocks, run paused after the second issue.
        cfg_inc[0] = 32'd2; cfg_ph[0] = 32'd0;
        cfg_inc[1] = 32'd3; cfg_ph[1] = 32'd1;
        cfg_inc[2] = 32'd7; cfg_ph[2] = 32'd0;
        cfg_ph[3]  = TIME_MAX;
        run_case("pause", 32'd25, 2, 0);

        // time_stop of zero: no event may ever be issued.
        cfg_inc[0] = 32'd1; cfg_ph[0] = 32'd0;
        for (int i = 1; i < N; i++) cfg_ph[i] = TIME_MAX;
        run_case("stop0", 32'd0, 0, 0);

        // One clock stuck at no-event, the rest inc 7.
        for (int i = 0; i < N; i++) begin
            cfg_inc[i] = 32'd7;
            cfg_ph[i]  = 32'(i);
        end
        cfg_ph[2] = TIME_MAX;
        run_case("stuck", 32'd30, 0, 0);

        // Asynchronous reset in the middle of WAIT, then a clean restart.
        cfg_inc[0] = 32'd3; cfg_ph[0] = 32'd0;
        cfg_inc[1] = 32'd5; cfg_ph[1] = 32'd0;
        cfg_ph[2]  = TIME_MAX;
        cfg_ph[3]  = TIME_MAX;
        run_case("rst_mid_wait", 32'd16, 0, 2);
        run_case("restart", 32'd16, 0, 0);

        for (int r = 0; r < 5; r++) begin
            nact = $urandom_range(1, N);
            for (int i = 0; i < N; i++) begin
                cfg_inc[i] = 32'($urandom_range(1, 9));
                cfg_ph[i]  = (i < nact) ? 32'($urandom_range(0, 6)) : TIME_MAX;
            end
            stop = 32'($urandom_range(10, 60));
            run_case($sformatf("rand%0d", r), stop, (r == 2) ? 3 : 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
